// File: rtl/adder_pipelined_nbit.sv
// Pipelined ripple-carry adder/subtractor: WIDTH bits split into STAGES chunks,
// one chunk resolved per cycle with the carry registered between stages.
module adder_pipelined_nbit #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int unsigned CHUNK = WIDTH / STAGES;

    if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("adder_pipelined_nbit: WIDTH must be a multiple of STAGES and STAGES >= 1");
    end

    logic                 advance;
    logic [STAGES-1:0]    vld_q;
    logic [STAGES-1:0]    vld_d;
    logic [STAGES-1:0]    c_q;
    logic [STAGES-1:0]    c_d;
    logic [WIDTH-1:0]     a_q [STAGES];
    logic [WIDTH-1:0]     a_d [STAGES];
    logic [WIDTH-1:0]     b_q [STAGES];
    logic [WIDTH-1:0]     b_d [STAGES];
    logic [WIDTH-1:0]     s_q [STAGES];
    logic [WIDTH-1:0]     s_d [STAGES];
    logic                 ovf_q;
    logic                 ovf_d;

    logic [WIDTH-1:0]     op_a;
    logic [WIDTH-1:0]     op_b;
    logic [WIDTH-1:0]     op_s;
    logic                 cy_in;
    logic [CHUNK-1:0]     ch_a;
    logic [CHUNK-1:0]     ch_b;
    logic [CHUNK-1:0]     ch_r;
    logic                 cy_out;

    // Global stall: the whole pipe moves only when the output slot can drain.
    assign advance  = !vld_q[STAGES-1] || out_ready;
    assign in_ready = advance;

    // Per-stage next state: stage k adds chunk k using the carry registered by stage k-1.
    always_comb begin
        vld_d  = '0;
        c_d    = '0;
        ovf_d  = 1'b0;
        op_a   = '0;
        op_b   = '0;
        op_s   = '0;
        cy_in  = 1'b0;
        ch_a   = '0;
        ch_b   = '0;
        ch_r   = '0;
        cy_out = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            a_d[k] = '0;
            b_d[k] = '0;
            s_d[k] = '0;
        end
        for (int k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                op_a     = a;
                op_b     = sub ? ~b : b;
                op_s     = '0;
                cy_in    = sub | carry_in;
                vld_d[0] = in_valid & advance;
            end else begin
                op_a     = a_q[k-1];
                op_b     = b_q[k-1];
                op_s     = s_q[k-1];
                cy_in    = c_q[k-1];
                vld_d[k] = vld_q[k-1];
            end
            ch_a = CHUNK'(op_a >> (k * CHUNK));
            ch_b = CHUNK'(op_b >> (k * CHUNK));
            {cy_out, ch_r} = {1'b0, ch_a} + {1'b0, ch_b} + {{CHUNK{1'b0}}, cy_in};
            op_s = (op_s & ~(WIDTH'({CHUNK{1'b1}}) << (k * CHUNK)))
                 | (WIDTH'(ch_r) << (k * CHUNK));
            a_d[k] = op_a;
            b_d[k] = op_b;
            s_d[k] = op_s;
            c_d[k] = cy_out;
            // Carry into the MSB recovered from its sum bit: s = a ^ b ^ cin.
            if (k == STAGES - 1) begin
                ovf_d = ch_r[CHUNK-1] ^ ch_a[CHUNK-1] ^ ch_b[CHUNK-1] ^ cy_out;
            end
        end
    end

    // Data registers load only behind a valid token, so bubbles leave results untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (advance) begin
            vld_q <= vld_d;
            for (int k = 0; k < STAGES; k++) begin
                if (vld_d[k]) begin
                    a_q[k] <= a_d[k];
                    b_q[k] <= b_d[k];
                    s_q[k] <= s_d[k];
                    c_q[k] <= c_d[k];
                end
            end
            if (vld_d[STAGES-1]) begin
                ovf_q <= ovf_d;
            end
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign carry_out = c_q[STAGES-1];
    assign overflow  = ovf_q;

    // Simulation-only input sanity checks.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!$isunknown(in_valid)) else $error("in_valid is X/Z");
            assert (!$isunknown(out_ready)) else $error("out_ready is X/Z");
            if (in_valid === 1'b1) begin
                assert (!$isunknown(a)) else $error("a has X/Z bits");
                assert (!$isunknown(b)) else $error("b has X/Z bits");
                assert (!$isunknown(carry_in)) else $error("carry_in is X/Z");
                assert (!$isunknown(sub)) else $error("sub is X/Z");
            end
        end
    end

endmodule

// File: tb/tb_adder_pipelined_nbit.sv
// Directed bench for adder_pipelined_nbit (16/4) plus reference-model sweeps
// on 32/1, 8/2 and 32/8 configurations.
module tb_adder_pipelined_nbit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        carry_in;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        carry_out;
    logic        overflow;

    adder_pipelined_nbit #(.WIDTH(16), .STAGES(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    // One operation through an idle pipe; checks latency, result and hold afterwards.
    task automatic run_single(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                              input logic icin, input logic isub, input logic [15:0] es,
                              input logic ec, input logic eo);
        int lat;
        @(negedge clk);
        in_valid = 1'b1; a = ia; b = ib; carry_in = icin; sub = isub; out_ready = 1'b1;
        #1;
        check_eq({tag, " in_ready"}, 64'(in_ready), 64'd1);
        lat = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            lat++;
        end while (!out_valid && lat < 20);
        check_eq({tag, " latency"}, 64'(lat), 64'd4);
        check_eq({tag, " out_valid"}, 64'(out_valid), 64'd1);
        check_eq({tag, " sum"}, 64'(sum), 64'(es));
        check_eq({tag, " cout/ovf"}, 64'({carry_out, overflow}), 64'({ec, eo}));
        @(negedge clk);
        #1;
        check_eq({tag, " drained"}, 64'(out_valid), 64'd0);
        check_eq({tag, " sum hold"}, 64'(sum), 64'(es));
    endtask

    // Parameter sweeps against an independent reference model, out_ready held high.
    for (genvar g = 0; g < 3; g++) begin : g_sweep
        localparam int unsigned SW = (g == 1) ? 8 : 32;
        localparam int unsigned SS = (g == 0) ? 1 : ((g == 1) ? 2 : 8);

        logic          s_rst;
        logic          s_iv;
        logic          s_ir;
        logic [SW-1:0] s_a;
        logic [SW-1:0] s_b;
        logic          s_cin;
        logic          s_sub;
        logic          s_ov;
        logic          s_or;
        logic [SW-1:0] s_sum;
        logic          s_co;
        logic          s_of;
        bit            done = 1'b0;
        logic [SW+1:0] exp_q [$];
        int            cyc_q [$];

        adder_pipelined_nbit #(.WIDTH(SW), .STAGES(SS)) u_dut (
            .clk       (clk),
            .rst       (s_rst),
            .in_valid  (s_iv),
            .in_ready  (s_ir),
            .a         (s_a),
            .b         (s_b),
            .carry_in  (s_cin),
            .sub       (s_sub),
            .out_valid (s_ov),
            .out_ready (s_or),
            .sum       (s_sum),
            .carry_out (s_co),
            .overflow  (s_of)
        );

        initial begin
            int            cyc;
            int            ops;
            int            due;
            logic [SW-1:0] be;
            logic [SW:0]   full;
            logic          ovf;
            logic [SW+1:0] e;
            s_rst = 1'b1; s_iv = 1'b0; s_or = 1'b1;
            s_a = '0; s_b = '0; s_cin = 1'b0; s_sub = 1'b0;
            repeat (2) @(negedge clk);
            s_rst = 1'b0;
            cyc = 0;
            ops = 0;
            while ((ops < 1000 || exp_q.size() > 0) && cyc < 3000) begin
                @(negedge clk);
                if (s_ov) begin
                    check_eq($sformatf("sweep%0d expected pending", g), 64'(exp_q.size() > 0), 64'd1);
                    if (exp_q.size() > 0) begin
                        e   = exp_q.pop_front();
                        due = cyc_q.pop_front();
                        check_eq($sformatf("sweep%0d result", g), 64'({s_co, s_of, s_sum}), 64'(e));
                        check_eq($sformatf("sweep%0d latency", g), 64'(cyc), 64'(due));
                    end
                end
                s_iv  = (ops < 1000) && ($urandom_range(0, 9) < 8);
                s_a   = SW'($urandom());
                s_b   = SW'($urandom());
                s_cin = 1'($urandom_range(0, 1));
                s_sub = 1'($urandom_range(0, 1));
                #1;
                if (s_iv && s_ir) begin
                    be   = s_sub ? ~s_b : s_b;
                    full = {1'b0, s_a} + {1'b0, be} + (SW+1)'(s_sub | s_cin);
                    ovf  = (s_a[SW-1] == be[SW-1]) && (full[SW-1] != s_a[SW-1]);
                    exp_q.push_back({full[SW], ovf, full[SW-1:0]});
                    cyc_q.push_back(cyc + int'(SS));
                    ops++;
                end
                cyc++;
            end
            s_iv = 1'b0;
            check_eq($sformatf("sweep%0d drain", g), 64'(exp_q.size()), 64'd0);
            check_eq($sformatf("sweep%0d ops", g), 64'(ops), 64'd1000);
            done = 1'b1;
        end
    end

    initial begin
        int          sent;
        int          rx;
        int          cyc;
        int          w;
        bit          prev_stall;
        logic [15:0] prev_sum;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; carry_in = 1'b0; sub = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("reset out_valid", 64'(out_valid), 64'd0);
        check_eq("reset sum", 64'(sum), 64'd0);
        check_eq("reset cout/ovf", 64'({carry_out, overflow}), 64'd0);
        check_eq("reset in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;

        run_single("add wrap",     16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_single("add sovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_single("sub borrow",   16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_single("sub sovf",     16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        run_single("add cin chunk", 16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);
        run_single("sub zero",     16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);

        // Eight back-to-back adds with out_ready low for three cycles.
        sent = 0; rx = 0; cyc = 0; prev_stall = 1'b0; prev_sum = '0;
        while (rx < 8 && cyc < 60) begin
            @(negedge clk);
            out_ready = !(cyc >= 5 && cyc <= 7);
            in_valid  = (sent < 8);
            a         = 16'(sent + 1);
            b         = 16'(32'h1000 * (sent + 1));
            carry_in  = 1'b0;
            sub       = 1'b0;
            #1;
            if (prev_stall) begin
                check_eq("stall valid hold", 64'(out_valid), 64'd1);
                check_eq("stall sum hold", 64'(sum), 64'(prev_sum));
            end
            check_eq("stream in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
            if (out_valid && out_ready) begin
                check_eq("stream sum", 64'(sum), 64'(16'(32'h1001 * (rx + 1))));
                check_eq("stream cout/ovf", 64'({carry_out, overflow}), 64'd0);
                rx++;
            end
            prev_stall = out_valid && !out_ready;
            prev_sum   = sum;
            if (in_valid && in_ready) sent++;
            cyc++;
        end
        check_eq("stream count", 64'(rx), 64'd8);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        check_eq("stream no extra", 64'(out_valid), 64'd0);

        // Reset lands one cycle before the first of three in-flight results.
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 16'(i * 3); b = 16'(i * 5); carry_in = 1'b0; sub = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        #1;
        check_eq("flush pre-reset valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("flush sum cleared", 64'(sum), 64'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            check_eq("flush no output", 64'(out_valid), 64'd0);
        end
        run_single("after flush", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);

        w = 0;
        while (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done) && w < 5000) begin
            @(negedge clk);
            w++;
        end
        check_eq("sweeps complete", 64'(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
